alu_mul_sequencer: RTL

- Multi-cycle controller that sequences the shared 8-bit ALU (dALU) to compute an unsigned 8x8 -> 16-bit product by shift-and-add.
- Sits between a requester (start/operands) and the ALU. Drives ALU op/A/B every cycle and consumes the ALU result and carry flag.
- The missing right-shift is done in sequencer wiring, not in the ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/dalu.sv | 59 +++++
 rtl/alu_mul_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the multiply
// sequencer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;

  localparam int FLAGS_ZERO     = 0;
  localparam int FLAGS_CARRY    = 1;
  localparam int FLAGS_SIGN     = 2;
  localparam int FLAGS_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dalu.sv
// Shared 8-bit datapath ALU (dALU): combinational result plus
// zero/carry/sign/overflow flags.
module dalu
  import alu_pkg::*;
(
  input  logic [3:0]           op,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic [ALU_WIDTH-1:0] result,
  output logic [3:0]           flags
);

  logic [ALU_WIDTH:0] wide;
  logic               carry;
  logic               ovf;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_PASS: result = a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[ALU_WIDTH-1:0];
        carry  = wide[ALU_WIDTH];
        ovf    = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
                 (result[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
      end
      OP_SUB: begin
        // carry reports borrow on subtract
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[ALU_WIDTH-1:0];
        carry  = wide[ALU_WIDTH];
        ovf    = (a[ALU_WIDTH-1] != b[ALU_WIDTH-1]) &&
                 (result[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
      end
      OP_SHL: begin
        result = {a[ALU_WIDTH-2:0], 1'b0};
        carry  = a[ALU_WIDTH-1];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags                 = '0;
    flags[FLAGS_ZERO]     = (result == '0);
    flags[FLAGS_CARRY]    = carry;
    flags[FLAGS_SIGN]     = result[ALU_WIDTH-1];
    flags[FLAGS_OVERFLOW] = ovf;
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Unsigned 8x8 shift-and-add multiplier that borrows the shared dALU for its
// adds; the right shift of {carry, sum, lo} is done here in wiring.
//
// state | meaning
// IDLE  | waiting for start, product held
// CALC  | one add+shift iteration per cycle, 8 cycles
// DONE  | product valid, done pulse
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 prod_hi_nz,
  output logic                 prod_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             alu_carry;
  logic             unused_flags;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] lo_next;

  // ALU inputs are parked at zero outside CALC to keep it quiet
  always_comb begin
    alu_op = OP_PASS;
    alu_a  = '0;
    alu_b  = '0;
    if (state == CALC) begin
      alu_op = OP_ADD;
      alu_a  = acc;
      alu_b  = lo[0] ? mcand : '0;
    end
  end

  dalu u_dalu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_out),
    .flags  (alu_flags)
  );

  assign alu_carry    = alu_flags[FLAGS_CARRY];
  assign unused_flags = ^{alu_flags[FLAGS_ZERO], alu_flags[FLAGS_SIGN],
                          alu_flags[FLAGS_OVERFLOW]};

  // {acc, lo} <= {carry, sum, lo} >> 1
  assign acc_next = {alu_carry, alu_out[WIDTH-1:1]};
  assign lo_next  = {alu_out[0], lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      lo         <= '0;
      mcand      <= '0;
      cnt        <= '0;
      product    <= '0;
      prod_zero  <= 1'b1;
      prod_hi_nz <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            lo    <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          lo  <= lo_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            product    <= {acc_next, lo_next};
            prod_zero  <= ({acc_next, lo_next} == '0);
            prod_hi_nz <= (acc_next != '0);
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
